crl78hcapbbseq: RTL and testbench



---
 rtl/crl78hcapbbseq_pkg.sv | 11 +
 rtl/crl78hcapbbseq_if.sv | 22 ++
 rtl/crl78hcapbbseq.sv | 110 +++++++++++
 tb/tb_crl78hcapbbseq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/crl78hcapbbseq_pkg.sv
// crl78hcap_pkg: shared state type and source indices for the BB clock-gate sequencer
package crl78hcap_pkg;
  typedef enum logic [1:0] {IDLE, ENTER, ON, EXIT} bb_state_e;
  localparam int NUM_BBSRC = 6;
  localparam logic [2:0] SRC_FCLKRT  = 3'd0;
  localparam logic [2:0] SRC_FMAIN   = 3'd1;
  localparam logic [2:0] SRC_FSUB    = 3'd2;
  localparam logic [2:0] SRC_OSCOUTM = 3'd3;
  localparam logic [2:0] SRC_R32MOUT = 3'd4;
  localparam logic [2:0] SRC_R15KOUT = 3'd5;
endpackage

// File: rtl/crl78hcapbbseq_if.sv
// crl78hcapbbseq_if: mode request, config and staggered gate-enable bundle
interface crl78hcapbbseq_if #(
  parameter int SETTLE_W = 4
);
  import crl78hcap_pkg::*;
  logic                 mod_scanmode;
  logic                 capmx_bbreq;
  logic [NUM_BBSRC-1:0] cfg_mask;
  logic [SETTLE_W-1:0]  cfg_settle;
  logic [NUM_BBSRC-1:0] bb_en;
  logic                 capmx_bbmode;
  logic                 bb_busy;
  logic                 bb_done;
  modport master (
    output mod_scanmode, capmx_bbreq, cfg_mask, cfg_settle,
    input  bb_en, capmx_bbmode, bb_busy, bb_done
  );
  modport slave (
    input  mod_scanmode, capmx_bbreq, cfg_mask, cfg_settle,
    output bb_en, capmx_bbmode, bb_busy, bb_done
  );
endinterface

// File: rtl/crl78hcapbbseq.sv
// crl78hcapbbseq: walks the six BB clock-gate enables on/off one source at a time with a settle gap
module crl78hcapbbseq
  import crl78hcap_pkg::*;
#(
  parameter int SETTLE_W = 4
) (
  input logic clk_fclkrt,
  input logic rst_capres,
  crl78hcapbbseq_if.slave bb
);
  bb_state_e            state;
  logic [2:0]           idx;
  logic [2:0]           idx_up;
  logic [2:0]           idx_dn;
  logic [SETTLE_W-1:0]  cnt;
  logic [SETTLE_W-1:0]  settle;
  logic [NUM_BBSRC-1:0] mask;
  logic [NUM_BBSRC-1:0] en_r;
  logic                 pend;
  logic                 mode_r;
  logic                 busy_r;
  logic                 done_r;
  assign idx_up = idx + 3'd1;
  assign idx_dn = idx - 3'd1;
  function automatic logic [SETTLE_W-1:0] step_cnt(input logic [2:0] i);
    return mask[i] ? settle : '0;
  endfunction
  // pend marks the acceptance cycle: config is latched but step 0 starts one edge later
  always_ff @(posedge clk_fclkrt or posedge rst_capres) begin
    if (rst_capres) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      settle <= '0;
      mask   <= '0;
      en_r   <= '0;
      pend   <= 1'b0;
      mode_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (bb.mod_scanmode) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      en_r   <= '0;
      pend   <= 1'b0;
      mode_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bb.capmx_bbreq) begin
          mask   <= bb.cfg_mask;
          settle <= bb.cfg_settle;
          idx    <= SRC_FCLKRT;
          pend   <= 1'b1;
          state  <= ENTER;
        end
        ENTER: if (!bb.capmx_bbreq) begin
          state     <= EXIT;
          pend      <= 1'b0;
          busy_r    <= 1'b1;
          cnt       <= step_cnt(idx);
          en_r[idx] <= 1'b0;
        end else if (pend) begin
          pend      <= 1'b0;
          busy_r    <= 1'b1;
          cnt       <= step_cnt(idx);
          en_r[idx] <= mask[idx];
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (idx == SRC_R15KOUT) begin
          state  <= ON;
          mode_r <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          idx          <= idx_up;
          cnt          <= step_cnt(idx_up);
          en_r[idx_up] <= mask[idx_up];
        end
        ON: if (!bb.capmx_bbreq) begin
          state             <= EXIT;
          mode_r            <= 1'b0;
          busy_r            <= 1'b1;
          idx               <= SRC_R15KOUT;
          cnt               <= step_cnt(SRC_R15KOUT);
          en_r[SRC_R15KOUT] <= 1'b0;
        end
        EXIT: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (idx == SRC_FCLKRT) begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          idx          <= idx_dn;
          cnt          <= step_cnt(idx_dn);
          en_r[idx_dn] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // fclk gate is held open under scan regardless of sequencer state
  assign bb.bb_en        = en_r | {{(NUM_BBSRC-1){1'b0}}, bb.mod_scanmode};
  assign bb.capmx_bbmode = mode_r;
  assign bb.bb_busy      = busy_r;
  assign bb.bb_done      = done_r;
endmodule

// File: tb/tb_crl78hcapbbseq.sv
// tb_crl78hcapbbseq: event-schedule reference model vs. BB sequencer, directed + random trials
module tb_crl78hcapbbseq;
  import crl78hcap_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    logic [5:0] m;
    logic [3:0] s;
    int         r;
    bit         re;
  } trial_t;
  trial_t plan[$];
  crl78hcapbbseq_if #(.SETTLE_W(4)) bb ();
  crl78hcapbbseq #(.SETTLE_W(4)) dut (
    .clk_fclkrt(clk),
    .rst_capres(rst),
    .bb(bb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One sequence from the edge E0 that accepts the request to the end of the exit.
  // Expectations come from per-source set/clear times derived from the step lengths.
  task automatic trial(input logic [5:0] m, input logic [3:0] s, input int r, input bit re,
                       input logic [5:0] nm, input logic [3:0] ns);
    int len[6];
    int start[6];
    int clr[6];
    int total, k, idle_t, last;
    logic [5:0] e;
    total = 0;
    k = 0;
    for (int j = 0; j < 6; j++) begin
      len[j]   = m[j] ? int'(s) + 1 : 1;
      start[j] = 1 + total;
      total   += len[j];
      clr[j]   = 0;
    end
    for (int j = 0; j < 6; j++) if (start[j] <= r - 1) k = j;
    idle_t = r;
    for (int j = k; j >= 0; j--) begin
      clr[j] = idle_t;
      idle_t += len[j];
    end
    last = re ? idle_t : idle_t + 1;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 6; j++)
        e[j] = m[j] && (start[j] <= ((t < r) ? t : r - 1)) && !(j <= k && t >= clr[j]);
      chk($sformatf("bb_en m=%0h s=%0d r=%0d t=%0d", m, s, r, t), 8'(bb.bb_en), 8'(e));
      chk($sformatf("bbmode t=%0d", t), 8'(bb.capmx_bbmode), 8'(t >= total + 1 && t < r));
      chk($sformatf("busy t=%0d", t), 8'(bb.bb_busy),
          8'((t >= 1 && t <= total && t < r) || (t >= r && t < idle_t)));
      chk($sformatf("done t=%0d", t), 8'(bb.bb_done), 8'(t == idle_t));
      bb.capmx_bbreq = (t == last) || (t + 1 < r) || (re && t + 1 > r + 1);
      bb.cfg_mask    = (t >= idle_t) ? nm : 6'($urandom);
      bb.cfg_settle  = (t >= idle_t) ? ns : 4'($urandom);
    end
  endtask
  initial begin
    bb.mod_scanmode = 1'b0;
    bb.capmx_bbreq  = 1'b0;
    bb.cfg_mask     = 6'h3F;
    bb.cfg_settle   = 4'd2;
    #1;
    chk("reset bb_en", 8'(bb.bb_en), 8'h00);
    chk("reset bbmode", 8'(bb.capmx_bbmode), 8'h00);
    chk("reset busy", 8'(bb.bb_busy), 8'h00);
    chk("reset done", 8'(bb.bb_done), 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    plan.push_back('{6'h3F, 4'd2, 22, 1'b0});
    plan.push_back('{6'h01, 4'd3, 12, 1'b0});
    plan.push_back('{6'h3F, 4'd1, 6, 1'b0});
    plan.push_back('{6'h3F, 4'd2, 25, 1'b1});
    plan.push_back('{6'h15, 4'd1, 14, 1'b0});
    plan.push_back('{6'h00, 4'd5, 9, 1'b0});
    plan.push_back('{6'h3F, 4'd3, 1, 1'b1});
    plan.push_back('{6'h2A, 4'd0, 3, 1'b0});
    for (int i = 0; i < 24; i++) begin
      trial_t tr;
      tr.m  = 6'($urandom);
      tr.s  = 4'($urandom_range(0, 7));
      tr.r  = int'($urandom_range(1, 6 * (int'(tr.s) + 1) + 8));
      tr.re = 1'($urandom);
      plan.push_back(tr);
    end
    bb.cfg_mask    = plan[0].m;
    bb.cfg_settle  = plan[0].s;
    bb.capmx_bbreq = 1'b1;
    for (int i = 0; i < plan.size(); i++)
      trial(plan[i].m, plan[i].s, plan[i].r, plan[i].re,
            (i + 1 < plan.size()) ? plan[i+1].m : 6'h3F,
            (i + 1 < plan.size()) ? plan[i+1].s : 4'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("on before scan bbmode", 8'(bb.capmx_bbmode), 8'h01);
    chk("on before scan bb_en", 8'(bb.bb_en), 8'h3F);
    bb.mod_scanmode = 1'b1;
    @(posedge clk);
    #1;
    chk("scan bb_en", 8'(bb.bb_en), 8'h01);
    chk("scan bbmode", 8'(bb.capmx_bbmode), 8'h00);
    chk("scan busy", 8'(bb.bb_busy), 8'h00);
    chk("scan done", 8'(bb.bb_done), 8'h00);
    bb.capmx_bbreq = 1'b0;
    @(posedge clk);
    #1;
    bb.mod_scanmode = 1'b0;
    #1;
    chk("scan off bb_en", 8'(bb.bb_en), 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post scan done", 8'(bb.bb_done), 8'h00);
      chk("post scan busy", 8'(bb.bb_busy), 8'h00);
    end
    bb.cfg_mask    = 6'h3F;
    bb.cfg_settle  = 4'd3;
    bb.capmx_bbreq = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("pre reset bb_en", 8'(bb.bb_en), 8'h03);
    chk("pre reset busy", 8'(bb.bb_busy), 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset bb_en", 8'(bb.bb_en), 8'h00);
    chk("async reset busy", 8'(bb.bb_busy), 8'h00);
    chk("async reset bbmode", 8'(bb.capmx_bbmode), 8'h00);
    chk("async reset done", 8'(bb.bb_done), 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bb.capmx_bbreq = 1'b0;
    @(posedge clk);
    #1;
    chk("after reset bb_en", 8'(bb.bb_en), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
